// File: rtl/rdma_rd_arbiter_if.sv
// Bus bundle between the read-DMA engines, the arbiter and the shared HP read port.
//
// Handshake semantics (every valid/ready pair on this bundle): a transfer happens on a
// rising clk edge where valid and ready are both 1. Once valid is raised, the source keeps
// valid and its payload stable until that edge. ready may depend combinationally on valid.
//
// m_* signals face the engines (packed per engine, slice i = engine i).
// s_* signals face the shared HP slave port.
// modport master : the arbiter's view (serves the engines, masters the HP port).
// modport slave  : the environment's view (engines plus HP slave).
interface rdma_rd_arbiter_if #(
  parameter int NUM_M = 2,
  parameter int AW    = 32,
  parameter int DW    = 64
);
  // engine side
  logic [NUM_M-1:0]    m_arvalid;
  logic [NUM_M-1:0]    m_arready;
  logic [NUM_M*AW-1:0] m_araddr;
  logic [NUM_M*8-1:0]  m_arlen;
  logic [NUM_M-1:0]    m_rvalid;
  logic [NUM_M-1:0]    m_rready;
  logic [DW-1:0]       m_rdata;
  logic                m_rlast;
  // shared HP side
  logic                s_arvalid;
  logic                s_arready;
  logic [AW-1:0]       s_araddr;
  logic [7:0]          s_arlen;
  logic [1:0]          s_arid;
  logic                s_rvalid;
  logic                s_rready;
  logic [DW-1:0]       s_rdata;
  logic                s_rlast;
  logic [1:0]          s_rid;

  modport master (
    input  m_arvalid, m_araddr, m_arlen, m_rready,
    input  s_arready, s_rvalid, s_rdata, s_rlast, s_rid,
    output m_arready, m_rvalid, m_rdata, m_rlast,
    output s_arvalid, s_araddr, s_arlen, s_arid, s_rready
  );

  modport slave (
    output m_arvalid, m_araddr, m_arlen, m_rready,
    output s_arready, s_rvalid, s_rdata, s_rlast, s_rid,
    input  m_arready, m_rvalid, m_rdata, m_rlast,
    input  s_arvalid, s_araddr, s_arlen, s_arid, s_rready
  );
endinterface

// File: rtl/rdma_rd_arbiter.sv
// rdma_rd_arbiter: shares one AXI HP read port between NUM_M read-DMA engines.
// - Round-robin AR arbitration through a two-state FSM (IDLE / ADDR), at most one AR per
//   two cycles; the grant is held until its AR handshake.
// - An in-order grant FIFO (depth MAX_OUTS) records which engine owns each outstanding
//   burst; R beats are routed to the FIFO head and the head is popped on the last beat.
//   The HP slave must return bursts in AR order; routing never looks at s_rid.
// - Optional feature macro RDMA_ARB_RID_CHECK_EN: adds a sticky rid_err output that flags
//   any accepted beat whose s_rid differs from the FIFO head. Routing is unchanged.
// - dbg_state / dbg_occ expose the FSM state and the grant-FIFO occupancy.
// Reset is synchronous, active-high. MAX_OUTS must be a power of two, at least 2.
module rdma_rd_arbiter #(
  parameter int NUM_M    = 2,
  parameter int MAX_OUTS = 4,
  parameter int AW       = 32,
  parameter int DW       = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  rdma_rd_arbiter_if.master          bus,
`ifdef RDMA_ARB_RID_CHECK_EN
  output logic                       rid_err,
`endif
  output logic                       busy,
  output logic                       dbg_state,
  output logic [$clog2(MAX_OUTS):0]  dbg_occ
);

  localparam int PW = $clog2(MAX_OUTS);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ADDR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    rr_q;
  logic [1:0]    win;
  logic          win_found;

  logic [1:0]    fifo_q [MAX_OUTS];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   occ_q;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  logic [1:0]    head;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == (PW+1)'(MAX_OUTS));
  assign head       = fifo_q[rd_ptr_q];

  // AR accepted on the shared port pushes the grant; last R beat accepted pops the head.
  assign push = (state_q == S_ADDR) && bus.s_arready;
  assign pop  = bus.s_rvalid && bus.s_rready && bus.s_rlast;

  // Round-robin winner: first requesting engine at or after rr_q, wrapping.
  always_comb begin
    win       = 2'd0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (!win_found && bus.m_arvalid[i] && (((int'(rr_q) + k) % NUM_M) == i)) begin
          win_found = 1'b1;
          win       = 2'(i);
        end
      end
    end
  end

  // AR FSM next state: grant only when someone asks and the grant FIFO has room.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && !fifo_full) begin
          state_d = S_ADDR;
          gnt_d   = win;
        end
      end
      S_ADDR: begin
        if (bus.s_arready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // AR FSM state, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'd0;
      rr_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      if (push) begin
        rr_q <= (int'(gnt_q) == NUM_M - 1) ? 2'd0 : gnt_q + 2'd1;
      end
    end
  end

  // AR channel mux: the granted engine's request is presented on the shared port, and
  // only that engine sees the shared ARREADY.
  always_comb begin
    bus.s_arvalid = (state_q == S_ADDR);
    bus.s_araddr  = '0;
    bus.s_arlen   = '0;
    bus.s_arid    = '0;
    bus.m_arready = '0;
    if (state_q == S_ADDR) begin
      bus.s_arid = gnt_q;
      for (int i = 0; i < NUM_M; i++) begin
        if (gnt_q == 2'(i)) begin
          bus.s_araddr     = bus.m_araddr[i*AW +: AW];
          bus.s_arlen      = bus.m_arlen[i*8 +: 8];
          bus.m_arready[i] = bus.s_arready;
        end
      end
    end
  end

  // Grant FIFO: write pointer, read pointer and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < MAX_OUTS; i++) begin
        fifo_q[i] <= 2'd0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= gnt_q;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + (PW+1)'(1);
        2'b01:   occ_q <= occ_q - (PW+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // R channel routing by FIFO head. With nothing outstanding the shared port is not ready,
  // so a stray beat is never accepted, and data/last are held at 0.
  always_comb begin
    bus.m_rvalid = '0;
    bus.s_rready = 1'b0;
    bus.m_rdata  = '0;
    bus.m_rlast  = 1'b0;
    if (!fifo_empty) begin
      bus.m_rdata = bus.s_rdata;
      bus.m_rlast = bus.s_rlast;
      for (int i = 0; i < NUM_M; i++) begin
        if (head == 2'(i)) begin
          bus.m_rvalid[i] = bus.s_rvalid;
          bus.s_rready    = bus.m_rready[i];
        end
      end
    end
  end

`ifdef RDMA_ARB_RID_CHECK_EN
  // Sticky flag: an accepted beat carried an ID other than the engine we routed it to.
  always_ff @(posedge clk) begin
    if (rst) begin
      rid_err <= 1'b0;
    end else if (bus.s_rvalid && bus.s_rready && (bus.s_rid != head)) begin
      rid_err <= 1'b1;
    end
  end
`else
  // s_rid carries no meaning for routing in this build.
  logic unused_rid;
  assign unused_rid = ^bus.s_rid;
`endif

  // Status outputs.
  assign busy      = (state_q == S_ADDR) || !fifo_empty;
  assign dbg_state = state_q;
  assign dbg_occ   = occ_q;

endmodule

// File: tb/tb_rdma_rd_arbiter.sv
// Directed testbench for rdma_rd_arbiter: one task per scenario, inline comparisons,
// an expected-data queue for the backpressure scenario, and a single summary line.
module tb_rdma_rd_arbiter;
  localparam int NUM_M    = 2;
  localparam int MAX_OUTS = 4;
  localparam int AW       = 32;
  localparam int DW       = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic       dbg_state;
  logic [2:0] dbg_occ;
`ifdef RDMA_ARB_RID_CHECK_EN
  logic       rid_err;
`endif

  int nvec = 0;
  int nerr = 0;
  logic [DW-1:0] exp_q[$];

  rdma_rd_arbiter_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) bus();

  rdma_rd_arbiter #(.NUM_M(NUM_M), .MAX_OUTS(MAX_OUTS), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
`ifdef RDMA_ARB_RID_CHECK_EN
    .rid_err   (rid_err),
`endif
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_occ   (dbg_occ)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_arvalid = '0;
    bus.m_araddr  = '0;
    bus.m_arlen   = '0;
    bus.m_rready  = '0;
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b0;
    bus.s_rdata   = '0;
    bus.s_rlast   = 1'b0;
    bus.s_rid     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic set_req(input int e, input logic [AW-1:0] addr, input logic [7:0] len);
    bus.m_araddr[e*AW +: AW] = addr;
    bus.m_arlen[e*8 +: 8]    = len;
  endtask

  // HP slave AR side: wait (bounded) for s_arvalid, capture the request, accept it.
  task automatic ar_handshake(output logic [1:0] id, output logic [AW-1:0] addr,
                              output logic [7:0] len, output bit timeout);
    int n;
    n       = 0;
    timeout = 1'b0;
    id      = '0;
    addr    = '0;
    len     = '0;
    while (bus.s_arvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.s_arvalid !== 1'b1) begin
      timeout = 1'b1;
    end else begin
      id            = bus.s_arid;
      addr          = bus.s_araddr;
      len           = bus.s_arlen;
      bus.s_arready = 1'b1;
      tick();
      bus.s_arready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.m_arvalid = 2'b11;
    bus.m_rready  = 2'b11;
    bus.s_rvalid  = 1'b1;
    bus.s_rlast   = 1'b1;
    bus.s_rdata   = 64'hDEAD_BEEF_0000_0001;
    tick();
    settle();
    nvec++;
    if ({bus.s_arvalid, bus.m_arready, bus.m_rvalid, bus.s_rready, busy, dbg_state, dbg_occ} !== '0) begin
      nerr++;
      $display("FAIL reset_ctrl: {arv,arrdy,rv,rrdy,busy,st,occ}=%b expected all 0",
               {bus.s_arvalid, bus.m_arready, bus.m_rvalid, bus.s_rready, busy, dbg_state, dbg_occ});
    end
    nvec++;
    if (bus.m_rdata !== '0 || bus.m_rlast !== 1'b0 || bus.s_araddr !== '0 || bus.s_arlen !== '0 || bus.s_arid !== '0) begin
      nerr++;
      $display("FAIL reset_data: rdata=%h rlast=%b araddr=%h arlen=%h arid=%h expected all 0",
               bus.m_rdata, bus.m_rlast, bus.s_araddr, bus.s_arlen, bus.s_arid);
    end
`ifdef RDMA_ARB_RID_CHECK_EN
    nvec++;
    if (rid_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_rid_err: got %b expected 0", rid_err);
    end
`endif
    // out of reset, nothing outstanding: a stray beat must not be accepted
    rst = 1'b0;
    bus.m_arvalid = '0;
    tick();
    settle();
    nvec++;
    if (bus.s_rready !== 1'b0 || bus.m_rvalid !== 2'b00 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL stray_beat: s_rready=%b m_rvalid=%b busy=%b expected 0 00 0",
               bus.s_rready, bus.m_rvalid, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 32'h1000_0000, 8'd3);
    bus.m_arvalid = 2'b01;
    settle();
    nvec++;
    if (bus.s_arvalid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL single_pre: s_arvalid=%b busy=%b expected 0 0", bus.s_arvalid, busy);
    end
    tick();
    nvec++;
    if ({bus.s_arvalid, bus.s_arid, bus.s_araddr, bus.s_arlen, busy, bus.m_arready} !== {1'b1, 2'd0, 32'h1000_0000, 8'd3, 1'b1, 2'b00}) begin
      nerr++;
      $display("FAIL single_ar: arvalid=%b arid=%0d araddr=%h arlen=%0d busy=%b arready=%b expected 1 0 10000000 3 1 00",
               bus.s_arvalid, bus.s_arid, bus.s_araddr, bus.s_arlen, busy, bus.m_arready);
    end
    bus.s_arready = 1'b1;
    settle();
    nvec++;
    if (bus.m_arready !== 2'b01) begin
      nerr++;
      $display("FAIL single_arready: m_arready=%b expected 01", bus.m_arready);
    end
    tick();
    bus.s_arready = 1'b0;
    bus.m_arvalid = 2'b00;
    settle();
    nvec++;
    if (bus.s_arvalid !== 1'b0 || dbg_occ !== 3'd1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL single_after_ar: arvalid=%b occ=%0d busy=%b expected 0 1 1", bus.s_arvalid, dbg_occ, busy);
    end
    bus.m_rready = 2'b11;
    for (int b = 0; b < 4; b++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = 64'h0000_0000_0000_A000 + 64'(b);
      bus.s_rlast  = (b == 3);
      settle();
      nvec++;
      if (bus.m_rvalid !== 2'b01 || bus.s_rready !== 1'b1 || busy !== 1'b1 ||
          bus.m_rdata !== 64'h0000_0000_0000_A000 + 64'(b) || bus.m_rlast !== (b == 3)) begin
        nerr++;
        $display("FAIL single_beat%0d: rvalid=%b rready=%b busy=%b rdata=%h rlast=%b expected 01 1 1 %h %b",
                 b, bus.m_rvalid, bus.s_rready, busy, bus.m_rdata, bus.m_rlast,
                 64'h0000_0000_0000_A000 + 64'(b), (b == 3));
      end
      tick();
    end
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    settle();
    nvec++;
    if (dbg_occ !== 3'd0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL single_done: occ=%0d busy=%b expected 0 0", dbg_occ, busy);
    end
  endtask

  task automatic test_contention();
    logic [1:0]    id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    bit            to;
    logic [1:0]    exp_id;
    do_reset();
    set_req(0, 32'h2000_0000, 8'd0);
    set_req(1, 32'h3000_0000, 8'd0);
    bus.m_arvalid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      ar_handshake(id, addr, len, to);
      exp_id = 2'(n % 2);
      nvec++;
      if (to || id !== exp_id || addr !== ((exp_id == 2'd1) ? 32'h3000_0000 : 32'h2000_0000)) begin
        nerr++;
        $display("FAIL contention_grant%0d: timeout=%b arid=%0d araddr=%h expected 0 %0d %h",
                 n, to, id, addr, exp_id, ((exp_id == 2'd1) ? 32'h3000_0000 : 32'h2000_0000));
      end
    end
    settle();
    nvec++;
    if (dbg_occ !== 3'd4 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL contention_full: occ=%0d busy=%b expected 4 1", dbg_occ, busy);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      nvec++;
      if (bus.s_arvalid !== 1'b0) begin
        nerr++;
        $display("FAIL contention_hold%0d: s_arvalid=%b expected 0", c, bus.s_arvalid);
      end
    end
    bus.m_rready = 2'b11;
    bus.s_rvalid = 1'b1;
    bus.s_rlast  = 1'b1;
    bus.s_rdata  = 64'h1111_2222_3333_4444;
    settle();
    nvec++;
    if (bus.m_rvalid !== 2'b01 || bus.s_rready !== 1'b1) begin
      nerr++;
      $display("FAIL contention_pop_route: rvalid=%b rready=%b expected 01 1", bus.m_rvalid, bus.s_rready);
    end
    tick();
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    settle();
    nvec++;
    if (dbg_occ !== 3'd3 || bus.s_arvalid !== 1'b0) begin
      nerr++;
      $display("FAIL contention_after_pop: occ=%0d arvalid=%b expected 3 0", dbg_occ, bus.s_arvalid);
    end
    tick();
    nvec++;
    if (bus.s_arvalid !== 1'b1 || bus.s_arid !== 2'd0) begin
      nerr++;
      $display("FAIL contention_5th: arvalid=%b arid=%0d expected 1 0", bus.s_arvalid, bus.s_arid);
    end
    bus.m_arvalid = 2'b00;
  endtask

  task automatic test_interleave();
    logic [1:0]    id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    bit            to;
    logic [1:0]    exp_v;
    do_reset();
    set_req(1, 32'h4000_0000, 8'd1);
    set_req(0, 32'h5000_0000, 8'd3);
    bus.m_arvalid = 2'b10;
    ar_handshake(id, addr, len, to);
    bus.m_arvalid = 2'b01;
    nvec++;
    if (to || id !== 2'd1 || len !== 8'd1) begin
      nerr++;
      $display("FAIL interleave_ar1: timeout=%b arid=%0d arlen=%0d expected 0 1 1", to, id, len);
    end
    ar_handshake(id, addr, len, to);
    bus.m_arvalid = 2'b00;
    nvec++;
    if (to || id !== 2'd0 || len !== 8'd3 || addr !== 32'h5000_0000) begin
      nerr++;
      $display("FAIL interleave_ar0: timeout=%b arid=%0d arlen=%0d araddr=%h expected 0 0 3 50000000", to, id, len, addr);
    end
    bus.m_rready = 2'b11;
    bus.s_rid    = 2'd2;  // deliberately unrelated to the owner; routing is by order
    for (int b = 0; b < 6; b++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = 64'h0000_BEEF_0000_0000 + 64'(b);
      bus.s_rlast  = (b == 1) || (b == 5);
      settle();
      exp_v = (b < 2) ? 2'b10 : 2'b01;
      nvec++;
      if (bus.m_rvalid !== exp_v || bus.s_rready !== 1'b1 || bus.m_rdata !== 64'h0000_BEEF_0000_0000 + 64'(b)) begin
        nerr++;
        $display("FAIL interleave_beat%0d: rvalid=%b rready=%b rdata=%h expected %b 1 %h",
                 b, bus.m_rvalid, bus.s_rready, bus.m_rdata, exp_v, 64'h0000_BEEF_0000_0000 + 64'(b));
      end
      tick();
    end
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    settle();
    nvec++;
    if (dbg_occ !== 3'd0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL interleave_done: occ=%0d busy=%b expected 0 0", dbg_occ, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]    id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    bit            to;
    bit            stall;
    logic [DW-1:0] exp_d;
    int            b;
    int            cyc;
    do_reset();
    set_req(0, 32'h6000_0000, 8'd7);
    bus.m_arvalid = 2'b01;
    ar_handshake(id, addr, len, to);
    bus.m_arvalid = 2'b00;
    nvec++;
    if (to || id !== 2'd0) begin
      nerr++;
      $display("FAIL bp_ar: timeout=%b arid=%0d expected 0 0", to, id);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(64'h0000_C0DE_0000_0000 + 64'(i));
    b   = 0;
    cyc = 0;
    while (b < 8 && cyc < 40) begin
      stall        = (cyc >= 3) && (cyc < 8);
      bus.m_rready = stall ? 2'b10 : 2'b01;
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = 64'h0000_C0DE_0000_0000 + 64'(b);
      bus.s_rlast  = (b == 7);
      settle();
      nvec++;
      if (bus.s_rready !== !stall || bus.m_rvalid !== 2'b01) begin
        nerr++;
        $display("FAIL bp_cycle%0d: s_rready=%b m_rvalid=%b expected %b 01", cyc, bus.s_rready, bus.m_rvalid, !stall);
      end
      if (bus.m_rvalid[0] === 1'b1 && bus.m_rready[0] === 1'b1) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL bp_extra: engine received %h, expected no more beats", bus.m_rdata);
        end else begin
          exp_d = exp_q.pop_front();
          if (bus.m_rdata !== exp_d) begin
            nerr++;
            $display("FAIL bp_data: got %h expected %h", bus.m_rdata, exp_d);
          end
        end
      end
      if (bus.s_rready === 1'b1) b++;
      tick();
      cyc++;
    end
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    settle();
    nvec++;
    if (exp_q.size() != 0 || b != 8 || dbg_occ !== 3'd0) begin
      nerr++;
      $display("FAIL bp_end: left=%0d sent=%0d occ=%0d expected 0 8 0", exp_q.size(), b, dbg_occ);
    end
  endtask

  task automatic test_push_pop();
    logic [1:0]    id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    bit            to;
    do_reset();
    set_req(0, 32'h7000_0000, 8'd0);
    set_req(1, 32'h7100_0000, 8'd0);
    bus.m_arvalid = 2'b01;
    ar_handshake(id, addr, len, to);
    bus.m_arvalid = 2'b10;
    ar_handshake(id, addr, len, to);
    bus.m_arvalid = 2'b01;
    tick();
    nvec++;
    if (bus.s_arvalid !== 1'b1 || bus.s_arid !== 2'd0 || dbg_occ !== 3'd2) begin
      nerr++;
      $display("FAIL pp_setup: arvalid=%b arid=%0d occ=%0d expected 1 0 2", bus.s_arvalid, bus.s_arid, dbg_occ);
    end
    bus.s_arready = 1'b1;
    bus.m_rready  = 2'b11;
    bus.s_rvalid  = 1'b1;
    bus.s_rlast   = 1'b1;
    bus.s_rdata   = 64'h5555_AAAA_5555_AAAA;
    settle();
    nvec++;
    if (bus.m_rvalid !== 2'b01 || bus.s_rready !== 1'b1 || bus.m_arready !== 2'b01) begin
      nerr++;
      $display("FAIL pp_both: rvalid=%b rready=%b arready=%b expected 01 1 01", bus.m_rvalid, bus.s_rready, bus.m_arready);
    end
    tick();
    bus.s_arready = 1'b0;
    bus.m_arvalid = 2'b00;
    bus.s_rvalid  = 1'b0;
    settle();
    nvec++;
    if (dbg_occ !== 3'd2 || bus.s_arvalid !== 1'b0) begin
      nerr++;
      $display("FAIL pp_occ: occ=%0d arvalid=%b expected 2 0", dbg_occ, bus.s_arvalid);
    end
    bus.s_rvalid = 1'b1;
    settle();
    nvec++;
    if (bus.m_rvalid !== 2'b10) begin
      nerr++;
      $display("FAIL pp_head1: rvalid=%b expected 10", bus.m_rvalid);
    end
    tick();
    nvec++;
    if (bus.m_rvalid !== 2'b01) begin
      nerr++;
      $display("FAIL pp_head0: rvalid=%b expected 01", bus.m_rvalid);
    end
    tick();
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    settle();
    nvec++;
    if (dbg_occ !== 3'd0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL pp_done: occ=%0d busy=%b expected 0 0", dbg_occ, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]    id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    bit            to;
    do_reset();
    set_req(0, 32'h8000_0000, 8'd0);
    set_req(1, 32'h8100_0000, 8'd0);
    bus.m_arvalid = 2'b01;
    ar_handshake(id, addr, len, to);
    bus.m_arvalid = 2'b10;
    ar_handshake(id, addr, len, to);
    bus.m_arvalid = 2'b01;
    ar_handshake(id, addr, len, to);
    bus.m_arvalid = 2'b10;
    tick();
    nvec++;
    if (dbg_state !== 1'b1 || dbg_occ !== 3'd3 || bus.s_arvalid !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_setup: state=%b occ=%0d arvalid=%b expected 1 3 1", dbg_state, dbg_occ, bus.s_arvalid);
    end
    rst           = 1'b1;
    bus.m_rready  = 2'b11;
    bus.s_rvalid  = 1'b1;
    bus.s_rdata   = 64'h9999_0000_9999_0000;
    tick();
    nvec++;
    if ({bus.s_arvalid, bus.m_arready, bus.m_rvalid, bus.s_rready, busy, dbg_state, dbg_occ, bus.s_arid} !== '0 ||
        bus.m_rdata !== '0 || bus.s_araddr !== '0) begin
      nerr++;
      $display("FAIL rstmid_outputs: {arv,arrdy,rv,rrdy,busy,st,occ,arid}=%b rdata=%h araddr=%h expected all 0",
               {bus.s_arvalid, bus.m_arready, bus.m_rvalid, bus.s_rready, busy, dbg_state, dbg_occ, bus.s_arid},
               bus.m_rdata, bus.s_araddr);
    end
    rst = 1'b0;
    clear_inputs();
    settle();
  endtask

`ifdef RDMA_ARB_RID_CHECK_EN
  task automatic test_rid_err();
    logic [1:0]    id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    bit            to;
    do_reset();
    set_req(0, 32'hA000_0000, 8'd1);
    bus.m_arvalid = 2'b01;
    ar_handshake(id, addr, len, to);
    bus.m_arvalid = 2'b00;
    bus.m_rready  = 2'b01;
    bus.s_rvalid  = 1'b1;
    bus.s_rid     = 2'd1;
    bus.s_rlast   = 1'b0;
    settle();
    nvec++;
    if (rid_err !== 1'b0 || bus.m_rvalid !== 2'b01) begin
      nerr++;
      $display("FAIL rid_before: rid_err=%b rvalid=%b expected 0 01", rid_err, bus.m_rvalid);
    end
    tick();
    bus.s_rid   = 2'd0;
    bus.s_rlast = 1'b1;
    settle();
    nvec++;
    if (rid_err !== 1'b1) begin
      nerr++;
      $display("FAIL rid_set: rid_err=%b expected 1", rid_err);
    end
    tick();
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    tick();
    tick();
    nvec++;
    if (rid_err !== 1'b1 || dbg_occ !== 3'd0) begin
      nerr++;
      $display("FAIL rid_sticky: rid_err=%b occ=%0d expected 1 0", rid_err, dbg_occ);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    nvec++;
    if (rid_err !== 1'b0) begin
      nerr++;
      $display("FAIL rid_clear: rid_err=%b expected 0", rid_err);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_interleave();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
`ifdef RDMA_ARB_RID_CHECK_EN
    test_rid_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
